// File: rtl/cpu_status_flags_if.sv
// Bus between the 6502/2A03 sequencer/ALU and the status-flag block.
// Clock and reset are plain ports on the block itself.
interface cpu_status_flags_if;
    logic       alu_c_out;
    logic       alu_v_out;
    logic       alu_z_out;
    logic       alu_n_out;
    logic [3:0] flag_we;
    logic [2:0] flag_op;
    logic       bit_load;
    logic       p_load;
    logic       p_load_now;
    logic [7:0] r_data;
    logic       push_b;
    logic       set_i;
    logic [2:0] br_cond;
    logic       br_taken;
    logic [7:0] p_out;
    logic       c_flag;
    logic       poll;
    logic       nmi_n;
    logic       irq_n;
    logic       int_ack;
    logic       int_is_nmi;
    logic       nmi_pending;
    logic       irq_pending;

    modport master (
        output alu_c_out, alu_v_out, alu_z_out, alu_n_out,
        output flag_we, flag_op, bit_load, p_load, p_load_now, r_data,
        output push_b, set_i, br_cond, poll, nmi_n, irq_n, int_ack, int_is_nmi,
        input  br_taken, p_out, c_flag, nmi_pending, irq_pending
    );

    modport slave (
        input  alu_c_out, alu_v_out, alu_z_out, alu_n_out,
        input  flag_we, flag_op, bit_load, p_load, p_load_now, r_data,
        input  push_b, set_i, br_cond, poll, nmi_n, irq_n, int_ack, int_is_nmi,
        output br_taken, p_out, c_flag, nmi_pending, irq_pending
    );
endinterface

// File: rtl/cpu_status_flags.sv
// 6502/2A03 status register, branch evaluation and interrupt request tracking.
// Define CPU_DECIMAL_FLAG_EN to give D real storage; the 2A03 build leaves it out.
module cpu_status_flags #(
    parameter int NMI_SYNC_STAGES = 2
) (
    input logic               clock,
    input logic               reset,
    cpu_status_flags_if.slave bus
);

    typedef enum logic [2:0] {
        OP_NONE = 3'd0,
        OP_CLC  = 3'd1,
        OP_SEC  = 3'd2,
        OP_CLI  = 3'd3,
        OP_SEI  = 3'd4,
        OP_CLV  = 3'd5,
        OP_CLD  = 3'd6,
        OP_SED  = 3'd7
    } flag_op_e;

    flag_op_e op;
    assign op = flag_op_e'(bus.flag_op);

    logic n_q, n_d, v_q, v_d, i_q, i_d, z_q, z_d, c_q, c_d;
    logic i_eff_q, i_eff_d;
    logic nmi_prev_q, nmi_prev_d;
    logic nmi_pending_q, nmi_pending_d;
    logic irq_pending_q, irq_pending_d;
    logic [NMI_SYNC_STAGES-1:0] nmi_sync_q, nmi_sync_d;
    logic [NMI_SYNC_STAGES-1:0] irq_sync_q, irq_sync_d;
    logic nmi_sync, irq_sync, nmi_edge;
    logic d_q;

    // Status byte bits 5 and 4 never load; bit 3 is dropped without a D flag.
    logic unused_rdata;
    assign unused_rdata = ^{bus.r_data[5:3]};

    // Each flag takes the highest-priority source targeting it:
    // p_load, set_i, bit_load, flag_op, flag_we.
    always_comb begin
        n_d = n_q;
        v_d = v_q;
        i_d = i_q;
        z_d = z_q;
        c_d = c_q;

        if (bus.p_load)           n_d = bus.r_data[7];
        else if (bus.bit_load)    n_d = bus.r_data[7];
        else if (bus.flag_we[3])  n_d = bus.alu_n_out;

        if (bus.p_load)           v_d = bus.r_data[6];
        else if (bus.bit_load)    v_d = bus.r_data[6];
        else if (op == OP_CLV)    v_d = 1'b0;
        else if (bus.flag_we[2])  v_d = bus.alu_v_out;

        if (bus.p_load)           i_d = bus.r_data[2];
        else if (bus.set_i)       i_d = 1'b1;
        else if (op == OP_CLI)    i_d = 1'b0;
        else if (op == OP_SEI)    i_d = 1'b1;

        if (bus.p_load)           z_d = bus.r_data[1];
        else if (bus.bit_load)    z_d = bus.alu_z_out;
        else if (bus.flag_we[1])  z_d = bus.alu_z_out;

        if (bus.p_load)           c_d = bus.r_data[0];
        else if (op == OP_CLC)    c_d = 1'b0;
        else if (op == OP_SEC)    c_d = 1'b1;
        else if (bus.flag_we[0])  c_d = bus.alu_c_out;
    end

`ifdef CPU_DECIMAL_FLAG_EN
    logic d_d;

    always_comb begin
        d_d = d_q;
        if (bus.p_load)           d_d = bus.r_data[3];
        else if (op == OP_CLD)    d_d = 1'b0;
        else if (op == OP_SED)    d_d = 1'b1;
    end

    always_ff @(posedge clock) begin
        if (reset) d_q <= 1'b0;
        else       d_q <= d_d;
    end
`else
    assign d_q = 1'b0;
`endif

    // Interrupt lines are asynchronous; NMI_SYNC_STAGES is expected in 1..3.
    always_comb begin
        nmi_sync_d[0] = bus.nmi_n;
        irq_sync_d[0] = bus.irq_n;
        for (int s = 1; s < NMI_SYNC_STAGES; s++) begin
            nmi_sync_d[s] = nmi_sync_q[s-1];
            irq_sync_d[s] = irq_sync_q[s-1];
        end
    end

    assign nmi_sync = nmi_sync_q[NMI_SYNC_STAGES-1];
    assign irq_sync = irq_sync_q[NMI_SYNC_STAGES-1];
    assign nmi_edge = nmi_prev_q & ~nmi_sync;

    always_comb begin
        nmi_prev_d    = nmi_sync;
        nmi_pending_d = nmi_pending_q;
        irq_pending_d = irq_pending_q;
        i_eff_d       = i_eff_q;

        // A fresh edge outranks the acknowledge of the previous request.
        if (bus.int_ack && bus.int_is_nmi) nmi_pending_d = 1'b0;
        if (nmi_edge)                      nmi_pending_d = 1'b1;

        // The mask used at a poll is the I value from the previous boundary.
        if (bus.poll) begin
            irq_pending_d = ~irq_sync & ~i_eff_q;
            i_eff_d       = i_q;
        end
        if (bus.int_ack && !bus.int_is_nmi) irq_pending_d = 1'b0;
        if (bus.p_load && bus.p_load_now)   i_eff_d       = bus.r_data[2];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            n_q           <= 1'b0;
            v_q           <= 1'b0;
            i_q           <= 1'b1;
            z_q           <= 1'b0;
            c_q           <= 1'b0;
            i_eff_q       <= 1'b1;
            nmi_prev_q    <= 1'b0;
            nmi_pending_q <= 1'b0;
            irq_pending_q <= 1'b0;
            nmi_sync_q    <= '1;
            irq_sync_q    <= '1;
        end else begin
            n_q           <= n_d;
            v_q           <= v_d;
            i_q           <= i_d;
            z_q           <= z_d;
            c_q           <= c_d;
            i_eff_q       <= i_eff_d;
            nmi_prev_q    <= nmi_prev_d;
            nmi_pending_q <= nmi_pending_d;
            irq_pending_q <= irq_pending_d;
            nmi_sync_q    <= nmi_sync_d;
            irq_sync_q    <= irq_sync_d;
        end
    end

    // br_cond[2:1] picks the flag, br_cond[0] the polarity that takes the branch.
    always_comb begin
        bus.br_taken = 1'b0;
        case (bus.br_cond[2:1])
            2'b00:   bus.br_taken = (n_q == bus.br_cond[0]);
            2'b01:   bus.br_taken = (v_q == bus.br_cond[0]);
            2'b10:   bus.br_taken = (c_q == bus.br_cond[0]);
            2'b11:   bus.br_taken = (z_q == bus.br_cond[0]);
            default: bus.br_taken = 1'b0;
        endcase
    end

    assign bus.p_out       = {n_q, v_q, 1'b1, bus.push_b, d_q, i_q, z_q, c_q};
    assign bus.c_flag      = c_q;
    assign bus.nmi_pending = nmi_pending_q;
    assign bus.irq_pending = irq_pending_q;

endmodule

// File: tb/tb_cpu_status_flags.sv
// Self-checking bench for cpu_status_flags: vector table, randomized flag
// traffic against a reference model, and hand-built interrupt sequences.
module tb_cpu_status_flags;

    localparam int S = 2;
`ifdef CPU_DECIMAL_FLAG_EN
    localparam bit HAS_D = 1'b1;
`else
    localparam bit HAS_D = 1'b0;
`endif

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    cpu_status_flags_if bus();

    cpu_status_flags #(.NMI_SYNC_STAGES(S)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference status register, updated once per clock from the inputs.
    bit m_n, m_v, m_d, m_i, m_z, m_c;

    typedef struct {
        logic       rst;
        logic [3:0] we;
        logic [2:0] op;
        logic [3:0] alu;   // {n, v, z, c}
        logic       bl;
        logic       pl;
        logic       si;
        logic [7:0] rd;
        logic       pb;
        logic [2:0] bc;
        logic [7:0] ep_d;
        logic [7:0] ep_nod;
        logic       ebr;
        logic       ec;
    } vec_t;

    vec_t tbl[13];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        reset          = 1'b0;
        bus.alu_c_out  = 1'b0;
        bus.alu_v_out  = 1'b0;
        bus.alu_z_out  = 1'b0;
        bus.alu_n_out  = 1'b0;
        bus.flag_we    = 4'h0;
        bus.flag_op    = 3'd0;
        bus.bit_load   = 1'b0;
        bus.p_load     = 1'b0;
        bus.p_load_now = 1'b0;
        bus.r_data     = 8'h00;
        bus.push_b     = 1'b0;
        bus.set_i      = 1'b0;
        bus.br_cond    = 3'd0;
        bus.poll       = 1'b0;
        bus.nmi_n      = 1'b1;
        bus.irq_n      = 1'b1;
        bus.int_ack    = 1'b0;
        bus.int_is_nmi = 1'b0;
    endtask

    // Apply sources from lowest to highest priority so the stronger one lands last.
    task automatic model_update();
        if (reset) begin
            {m_n, m_v, m_d, m_z, m_c} = 5'b0;
            m_i = 1'b1;
            return;
        end
        if (bus.flag_we[0]) m_c = bus.alu_c_out;
        if (bus.flag_we[1]) m_z = bus.alu_z_out;
        if (bus.flag_we[2]) m_v = bus.alu_v_out;
        if (bus.flag_we[3]) m_n = bus.alu_n_out;
        case (bus.flag_op)
            3'd1: m_c = 1'b0;
            3'd2: m_c = 1'b1;
            3'd3: m_i = 1'b0;
            3'd4: m_i = 1'b1;
            3'd5: m_v = 1'b0;
            3'd6: if (HAS_D) m_d = 1'b0;
            3'd7: if (HAS_D) m_d = 1'b1;
            default: ;
        endcase
        if (bus.bit_load) begin
            m_n = bus.r_data[7];
            m_v = bus.r_data[6];
            m_z = bus.alu_z_out;
        end
        if (bus.set_i) m_i = 1'b1;
        if (bus.p_load) begin
            m_n = bus.r_data[7];
            m_v = bus.r_data[6];
            if (HAS_D) m_d = bus.r_data[3];
            m_i = bus.r_data[2];
            m_z = bus.r_data[1];
            m_c = bus.r_data[0];
        end
    endtask

    function automatic logic [7:0] model_p(input logic pb);
        return {m_n, m_v, 1'b1, pb, m_d, m_i, m_z, m_c};
    endfunction

    function automatic logic model_br(input logic [2:0] cond);
        case (cond)
            3'd0: return !m_n;   // BPL
            3'd1: return m_n;    // BMI
            3'd2: return !m_v;   // BVC
            3'd3: return m_v;    // BVS
            3'd4: return !m_c;   // BCC
            3'd5: return m_c;    // BCS
            3'd6: return !m_z;   // BNE
            default: return m_z; // BEQ
        endcase
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
        model_update();
    endtask

    task automatic check_flags(input string tag);
        check({tag, "_p_out"}, bus.p_out, model_p(bus.push_b));
        check({tag, "_c_flag"}, {7'd0, bus.c_flag}, {7'd0, m_c});
        check({tag, "_br"}, {7'd0, bus.br_taken}, {7'd0, model_br(bus.br_cond)});
    endtask

    initial begin
        idle_inputs();
        reset = 1'b1;
        {m_n, m_v, m_d, m_i, m_z, m_c} = 6'b000100;
        repeat (2) step();
        reset = 1'b0;

        //            rst we     op    alu      bl pl si rd     pb bc    ep_d   ep_nod ebr ec
        tbl[0]  = '{1'b0, 4'h0, 3'd0, 4'b0000, 0, 0, 0, 8'h00, 1, 3'd6, 8'h34, 8'h34, 1, 0};
        tbl[1]  = '{1'b0, 4'hF, 3'd0, 4'b1001, 0, 0, 0, 8'h00, 0, 3'd5, 8'hA5, 8'hA5, 1, 1};
        tbl[2]  = '{1'b0, 4'h0, 3'd0, 4'b0000, 0, 0, 0, 8'h00, 0, 3'd0, 8'hA5, 8'hA5, 0, 1};
        tbl[3]  = '{1'b0, 4'h0, 3'd0, 4'b0000, 0, 1, 0, 8'hFF, 0, 3'd7, 8'hEF, 8'hE7, 1, 1};
        tbl[4]  = '{1'b0, 4'h0, 3'd1, 4'b0000, 0, 0, 0, 8'h00, 0, 3'd4, 8'hEE, 8'hE6, 1, 0};
        tbl[5]  = '{1'b0, 4'h3, 3'd2, 4'b0000, 0, 0, 0, 8'h00, 0, 3'd7, 8'hED, 8'hE5, 0, 1};
        tbl[6]  = '{1'b0, 4'h0, 3'd0, 4'b0010, 1, 0, 0, 8'h40, 1, 3'd3, 8'h7F, 8'h77, 1, 1};
        tbl[7]  = '{1'b0, 4'h0, 3'd3, 4'b0000, 0, 0, 1, 8'h00, 0, 3'd1, 8'h6F, 8'h67, 0, 1};
        tbl[8]  = '{1'b0, 4'h0, 3'd3, 4'b0000, 0, 0, 0, 8'h00, 0, 3'd2, 8'h6B, 8'h63, 0, 1};
        tbl[9]  = '{1'b0, 4'h0, 3'd6, 4'b0000, 0, 0, 0, 8'h00, 0, 3'd6, 8'h63, 8'h63, 0, 1};
        tbl[10] = '{1'b0, 4'h0, 3'd7, 4'b0000, 0, 0, 0, 8'h00, 0, 3'd5, 8'h6B, 8'h63, 1, 1};
        tbl[11] = '{1'b0, 4'hF, 3'd7, 4'b1111, 1, 1, 1, 8'h00, 0, 3'd6, 8'h20, 8'h20, 1, 0};
        tbl[12] = '{1'b1, 4'h0, 3'd0, 4'b0000, 0, 1, 0, 8'hFF, 1, 3'd6, 8'h34, 8'h34, 1, 0};

        for (int k = 0; k < 13; k++) begin
            reset         = tbl[k].rst;
            bus.flag_we   = tbl[k].we;
            bus.flag_op   = tbl[k].op;
            {bus.alu_n_out, bus.alu_v_out, bus.alu_z_out, bus.alu_c_out} = tbl[k].alu;
            bus.bit_load  = tbl[k].bl;
            bus.p_load    = tbl[k].pl;
            bus.set_i     = tbl[k].si;
            bus.r_data    = tbl[k].rd;
            bus.push_b    = tbl[k].pb;
            bus.br_cond   = tbl[k].bc;
            step();
            check($sformatf("vec%0d_p_out", k), bus.p_out, HAS_D ? tbl[k].ep_d : tbl[k].ep_nod);
            check($sformatf("vec%0d_c_flag", k), {7'd0, bus.c_flag}, {7'd0, tbl[k].ec});
            check($sformatf("vec%0d_br", k), {7'd0, bus.br_taken}, {7'd0, tbl[k].ebr});
        end
        check("reset_nmi_pending", {7'd0, bus.nmi_pending}, 8'd0);
        check("reset_irq_pending", {7'd0, bus.irq_pending}, 8'd0);
        idle_inputs();

        // Randomized flag traffic against the reference model.
        for (int k = 0; k < 400; k++) begin
            reset          = ($urandom_range(0, 39) == 0);
            bus.flag_we    = 4'($urandom_range(0, 15));
            bus.flag_op    = 3'($urandom_range(0, 7));
            bus.alu_c_out  = 1'($urandom_range(0, 1));
            bus.alu_v_out  = 1'($urandom_range(0, 1));
            bus.alu_z_out  = 1'($urandom_range(0, 1));
            bus.alu_n_out  = 1'($urandom_range(0, 1));
            bus.bit_load   = ($urandom_range(0, 3) == 0);
            bus.p_load     = ($urandom_range(0, 5) == 0);
            bus.p_load_now = 1'($urandom_range(0, 1));
            bus.set_i      = ($urandom_range(0, 5) == 0);
            bus.r_data     = 8'($urandom_range(0, 255));
            bus.push_b     = 1'($urandom_range(0, 1));
            bus.br_cond    = 3'($urandom_range(0, 7));
            step();
            check_flags($sformatf("rnd%0d", k));
        end

        // IRQ masking with the one-instruction I latency.
        idle_inputs();
        reset = 1'b1;
        step();
        reset = 1'b0;
        bus.irq_n = 1'b0;
        repeat (S + 1) step();
        check("irq_no_poll", {7'd0, bus.irq_pending}, 8'd0);
        bus.flag_op = 3'd3;
        step();
        bus.flag_op = 3'd0;
        bus.poll = 1'b1; step(); bus.poll = 1'b0;
        check("irq_poll1_masked", {7'd0, bus.irq_pending}, 8'd0);
        step();
        check("irq_no_poll_hold", {7'd0, bus.irq_pending}, 8'd0);
        bus.poll = 1'b1; step(); bus.poll = 1'b0;
        check("irq_poll2", {7'd0, bus.irq_pending}, 8'd1);
        repeat (3) step();
        check("irq_held", {7'd0, bus.irq_pending}, 8'd1);
        bus.int_ack = 1'b1; step(); bus.int_ack = 1'b0;
        check("irq_ack", {7'd0, bus.irq_pending}, 8'd0);
        bus.poll = 1'b1; bus.int_ack = 1'b1; step(); bus.poll = 1'b0; bus.int_ack = 1'b0;
        check("irq_ack_beats_poll", {7'd0, bus.irq_pending}, 8'd0);
        bus.poll = 1'b1; step(); bus.poll = 1'b0;
        check("irq_repoll", {7'd0, bus.irq_pending}, 8'd1);
        bus.irq_n = 1'b1;
        repeat (S + 1) step();
        check("irq_release_no_poll", {7'd0, bus.irq_pending}, 8'd1);
        bus.poll = 1'b1; step(); bus.poll = 1'b0;
        check("irq_release_poll", {7'd0, bus.irq_pending}, 8'd0);

        bus.irq_n = 1'b0;
        repeat (S + 1) step();
        bus.flag_op = 3'd4; step(); bus.flag_op = 3'd0;
        bus.poll = 1'b1; step(); bus.poll = 1'b0;
        check("irq_sei_late", {7'd0, bus.irq_pending}, 8'd1);
        bus.int_ack = 1'b1; step(); bus.int_ack = 1'b0;
        bus.poll = 1'b1; step(); bus.poll = 1'b0;
        check("irq_sei_masked", {7'd0, bus.irq_pending}, 8'd0);

        // RTI updates the mask at once; PLP waits for the next boundary.
        bus.flag_op = 3'd3; step(); bus.flag_op = 3'd0;
        bus.poll = 1'b1; step(); bus.poll = 1'b0;
        check("irq_cli_first_poll", {7'd0, bus.irq_pending}, 8'd0);
        bus.p_load = 1'b1; bus.p_load_now = 1'b1; bus.r_data = 8'h04;
        step();
        bus.p_load = 1'b0; bus.p_load_now = 1'b0; bus.r_data = 8'h00;
        bus.poll = 1'b1; step(); bus.poll = 1'b0;
        check("irq_rti_now", {7'd0, bus.irq_pending}, 8'd0);
        bus.p_load = 1'b1; bus.r_data = 8'h00; step(); bus.p_load = 1'b0;
        bus.poll = 1'b1; step(); bus.poll = 1'b0;
        check("irq_plp_late", {7'd0, bus.irq_pending}, 8'd0);
        bus.poll = 1'b1; step(); bus.poll = 1'b0;
        check("irq_plp_applied", {7'd0, bus.irq_pending}, 8'd1);
        bus.int_ack = 1'b1; step(); bus.int_ack = 1'b0;
        bus.irq_n = 1'b1;

        // NMI: a one-cycle pulse, then a long low hold.
        repeat (S + 2) step();
        bus.nmi_n = 1'b0;
        for (int k = 1; k <= S + 1; k++) begin
            step();
            bus.nmi_n = 1'b1;
            check($sformatf("nmi_pulse_lat%0d", k), {7'd0, bus.nmi_pending}, {7'd0, (k == S + 1)});
        end
        repeat (4) step();
        check("nmi_sticky", {7'd0, bus.nmi_pending}, 8'd1);
        bus.int_ack = 1'b1; bus.int_is_nmi = 1'b1; step(); bus.int_ack = 1'b0;
        check("nmi_ack", {7'd0, bus.nmi_pending}, 8'd0);
        repeat (S + 2) step();
        check("nmi_no_reassert", {7'd0, bus.nmi_pending}, 8'd0);

        begin
            int rises;
            logic last;
            rises = 0;
            last = 1'b0;
            bus.nmi_n = 1'b0;
            for (int k = 1; k <= 20; k++) begin
                bus.int_ack = (k == S + 3);
                step();
                bus.int_ack = 1'b0;
                if (bus.nmi_pending && !last) rises++;
                last = bus.nmi_pending;
                check($sformatf("nmi_hold%0d", k), {7'd0, bus.nmi_pending},
                      {7'd0, (k >= S + 1 && k <= S + 2)});
            end
            check("nmi_hold_one_request", 8'(rises), 8'd1);
        end

        // A new edge in the acknowledge cycle keeps the request alive.
        bus.nmi_n = 1'b1;
        repeat (S + 2) step();
        bus.nmi_n = 1'b0;
        repeat (S + 1) step();
        check("nmi_second_edge", {7'd0, bus.nmi_pending}, 8'd1);
        bus.nmi_n = 1'b1;
        repeat (S + 2) step();
        bus.nmi_n = 1'b0;
        repeat (S) step();
        bus.int_ack = 1'b1; step(); bus.int_ack = 1'b0;
        check("nmi_edge_beats_ack", {7'd0, bus.nmi_pending}, 8'd1);
        bus.int_ack = 1'b1; bus.int_is_nmi = 1'b0; step(); bus.int_ack = 1'b0;
        check("nmi_irq_ack_ignored", {7'd0, bus.nmi_pending}, 8'd1);
        bus.int_ack = 1'b1; bus.int_is_nmi = 1'b1; step(); bus.int_ack = 1'b0;
        check("nmi_final_ack", {7'd0, bus.nmi_pending}, 8'd0);

        // Reset overrides p_load and clears both requests.
        bus.irq_n = 1'b0;
        bus.flag_op = 3'd3; step(); bus.flag_op = 3'd0;
        bus.poll = 1'b1; repeat (2) step(); bus.poll = 1'b0;
        bus.nmi_n = 1'b1; repeat (S + 1) step();
        bus.nmi_n = 1'b0; repeat (S + 1) step();
        check("pre_reset_irq", {7'd0, bus.irq_pending}, 8'd1);
        check("pre_reset_nmi", {7'd0, bus.nmi_pending}, 8'd1);
        reset = 1'b1; bus.p_load = 1'b1; bus.r_data = 8'h00; bus.push_b = 1'b1;
        step();
        check("reset_pload_p_out", bus.p_out, 8'h34);
        check("reset_pload_irq", {7'd0, bus.irq_pending}, 8'd0);
        check("reset_pload_nmi", {7'd0, bus.nmi_pending}, 8'd0);
        idle_inputs();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
